xbar_job_ctrl: RTL and testbench
================================

Name: xbar_job_ctrl

Overview:
Sequencer in front of one crossbar MVM tile. Owns the tile's mem_en/read_en/calc_en/address/write-data pins. Arbitrates three request types onto the tile, one at a time:
- weight streaming (row-major byte load)
- single-cell readback
- compute jobs

For a compute job it runs the full calc_en/available handshake and reports completion or timeout upstream.

Parameters:
XBAR_R, 256, crossbar rows (weight load row count)
XBAR_C, 256, crossbar columns (weight load column count)
ADDR_W, 32, width of row/col address buses
TIMEOUT, 4096, max cycles a compute job may spend waiting on the tile before abort

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_start  in  1  pulse: begin weight load of XBAR_R*XBAR_C bytes
w_valid  in  1  weight byte valid
w_data  in  8  weight byte
w_ready  out  1  weight byte accepted when w_valid&w_ready
load_done  out  1  one-cycle pulse after last weight written
rb_valid  in  1  readback request
rb_row  in  ADDR_W  readback row
rb_col  in  ADDR_W  readback column
rb_ready  out  1  readback accepted when rb_valid&rb_ready
rb_data_valid  out  1  one-cycle pulse, rb_data valid
rb_data  out  8  readback byte (passthrough of xb_mem_read_out)
job_valid  in  1  compute request
job_ready  out  1  job accepted when job_valid&job_ready
job_done  out  1  one-cycle pulse, job finished (also on timeout)
job_error  out  1  one-cycle pulse with job_done when job timed out
busy  out  1  high in any state other than IDLE
xb_mem_en  out  1  to tile mem_en
xb_read_en  out  1  to tile read_en
xb_calc_en  out  1  to tile calc_en
xb_row_address  out  ADDR_W  to tile row_address
xb_col_address  out  ADDR_W  to tile col_address
xb_mem_write_in  out  8  to tile mem_write_in
xb_mem_read_out  in  8  from tile mem_read_out
xb_available  in  1  from tile available

Behaviour:

Outputs and reset
- All xb_* outputs, load_done, rb_data_valid, job_done and job_error are registered.
- On reset: state=IDLE, every registered output=0, load row/col counters=0, timeout counter=0.
- Reset asserted mid-operation aborts that operation. It has priority over everything. The outputs are 0 on the cycle after reset is sampled.

States: IDLE, LOAD, RD, CALC_START, CALC_RUN.

IDLE and arbitration
- Priority is cfg_start > rb_valid > job_valid, evaluated every IDLE cycle.
- rb_ready = IDLE & !cfg_start.
- job_ready = IDLE & !cfg_start & !rb_valid.
- cfg_start outside IDLE is ignored.

LOAD
- w_ready=1.
- Each accepted beat: on the next cycle xb_mem_en=1, xb_read_en=0, address=(row,col) counters, data=w_data. Then col increments; on col==XBAR_C-1, col wraps to 0 and row increments.
- Cycles without an accepted beat: xb_mem_en=0.
- After the beat at (XBAR_R-1, XBAR_C-1) is accepted: go to IDLE and clear counters. load_done pulses in the same cycle as the final write.
- w_ready=0 in every other state.

RD
- Entered on accept. For exactly one cycle: xb_mem_en=1, xb_read_en=1, address = captured rb_row/rb_col.
- In the following cycle: rb_data_valid=1, rb_data=xb_mem_read_out, state returns to IDLE.
- Readback latency is 2 cycles from accept to data.

CALC_START
- Entered on accept. xb_calc_en=1, xb_mem_en=0.
- Waits for xb_available==0, then goes to CALC_RUN.

CALC_RUN
- xb_calc_en held at 1. Waits for xb_available==1.
- On that cycle the next state is IDLE, and the next cycle has xb_calc_en=0 and job_done=1.
- xb_calc_en must drop the cycle after available returns; otherwise the tile restarts.

Timeout
- A counter runs in CALC_START and CALC_RUN.
- When it reaches TIMEOUT-1: go to IDLE, xb_calc_en=0, job_done=1 and job_error=1 on the next cycle, counter cleared.

General rules
- xb_mem_en and xb_calc_en are never both 1.
- Addresses hold their last value when unused.

Test Plan:
1. Reset with all inputs 0 -> busy=0, all xb_*=0, w_ready=0; job_ready=1, rb_ready=1.
2. cfg_start, then 65536 beats with w_data=(row+col)&8'hFF, w_valid toggled 1/0 every cycle -> exactly 65536 xb_mem_en writes, in row-major order, with addresses and data matching. load_done pulses once with the last write. Then IDLE.
3. After load, rb_valid with row=3, col=5 -> rb_data_valid 2 cycles after accept with rb_data=8. xb_read_en=1 for exactly one cycle.
4. Job with the real tile attached -> xb_calc_en high until 1 cycle after available returns to 1. job_done pulses once, job_error=0, no second tile pass starts.
5. Job with xb_available tied 1 -> abort after 4096 cycles: job_done=job_error=1 for one cycle, xb_calc_en=0.
6. cfg_start, rb_valid and job_valid asserted together in IDLE -> LOAD entered; rb_ready=job_ready=0. Reset asserted mid-load (beat 100) -> next cycle IDLE, outputs 0; a fresh cfg_start restarts at (0,0).

Source files
------------

// File: rtl/xbar_job_ctrl.sv
// Sequencer for one crossbar MVM tile: arbitrates weight loads, single-cell
// readbacks and compute jobs onto the tile pins, one operation at a time.
module xbar_job_ctrl #(
  parameter int unsigned XBAR_R  = 256,
  parameter int unsigned XBAR_C  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              w_valid,
  input  logic [7:0]        w_data,
  output logic              w_ready,
  output logic              load_done,
  input  logic              rb_valid,
  input  logic [ADDR_W-1:0] rb_row,
  input  logic [ADDR_W-1:0] rb_col,
  output logic              rb_ready,
  output logic              rb_data_valid,
  output logic [7:0]        rb_data,
  input  logic              job_valid,
  output logic              job_ready,
  output logic              job_done,
  output logic              job_error,
  output logic              busy,
  output logic              xb_mem_en,
  output logic              xb_read_en,
  output logic              xb_calc_en,
  output logic [ADDR_W-1:0] xb_row_address,
  output logic [ADDR_W-1:0] xb_col_address,
  output logic [7:0]        xb_mem_write_in,
  input  logic [7:0]        xb_mem_read_out,
  input  logic              xb_available
);

  localparam int unsigned ROW_W = (XBAR_R > 1) ? $clog2(XBAR_R) : 1;
  localparam int unsigned COL_W = (XBAR_C > 1) ? $clog2(XBAR_C) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(XBAR_R - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(XBAR_C - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD,
    S_CALC_START,
    S_CALC_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              mem_en_q, mem_en_d;
  logic              read_en_q, read_en_d;
  logic              calc_en_q, calc_en_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [ADDR_W-1:0] col_addr_q, col_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              load_done_q, load_done_d;
  logic              rb_dv_q, rb_dv_d;
  logic              job_done_q, job_done_d;
  logic              job_error_q, job_error_d;

  logic idle;

  assign idle      = (state_q == S_IDLE);
  assign busy      = !idle;
  assign w_ready   = (state_q == S_LOAD);
  assign rb_ready  = idle && !cfg_start;
  assign job_ready = idle && !cfg_start && !rb_valid;
  assign rb_data   = xb_mem_read_out;

  assign xb_mem_en       = mem_en_q;
  assign xb_read_en      = read_en_q;
  assign xb_calc_en      = calc_en_q;
  assign xb_row_address  = row_addr_q;
  assign xb_col_address  = col_addr_q;
  assign xb_mem_write_in = wdata_q;
  assign load_done       = load_done_q;
  assign rb_data_valid   = rb_dv_q;
  assign job_done        = job_done_q;
  assign job_error       = job_error_q;

  // Next-state and registered-output logic; enables and pulses default low,
  // address/data hold their last value.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    to_d        = '0;
    mem_en_d    = 1'b0;
    read_en_d   = 1'b0;
    calc_en_d   = 1'b0;
    row_addr_d  = row_addr_q;
    col_addr_d  = col_addr_q;
    wdata_d     = wdata_q;
    load_done_d = 1'b0;
    rb_dv_d     = 1'b0;
    job_done_d  = 1'b0;
    job_error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end else if (rb_valid) begin
          state_d    = S_RD;
          mem_en_d   = 1'b1;
          read_en_d  = 1'b1;
          row_addr_d = rb_row;
          col_addr_d = rb_col;
        end else if (job_valid) begin
          state_d   = S_CALC_START;
          calc_en_d = 1'b1;
        end
      end

      S_LOAD: begin
        if (w_valid) begin
          mem_en_d   = 1'b1;
          row_addr_d = ADDR_W'(row_q);
          col_addr_d = ADDR_W'(col_q);
          wdata_d    = w_data;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d       = '0;
              state_d     = S_IDLE;
              load_done_d = 1'b1;
            end else begin
              row_d = ROW_W'(row_q + 1'b1);
            end
          end else begin
            col_d = COL_W'(col_q + 1'b1);
          end
        end
      end

      S_RD: begin
        rb_dv_d = 1'b1;
        state_d = S_IDLE;
      end

      S_CALC_START: begin
        calc_en_d = 1'b1;
        to_d      = TO_W'(to_q + 1'b1);
        if (to_q == TO_LAST) begin
          state_d     = S_IDLE;
          calc_en_d   = 1'b0;
          to_d        = '0;
          job_done_d  = 1'b1;
          job_error_d = 1'b1;
        end else if (!xb_available) begin
          state_d = S_CALC_RUN;
        end
      end

      S_CALC_RUN: begin
        calc_en_d = 1'b1;
        to_d      = TO_W'(to_q + 1'b1);
        // Drop calc_en right after available returns so the tile does not rerun.
        if (xb_available) begin
          state_d    = S_IDLE;
          calc_en_d  = 1'b0;
          to_d       = '0;
          job_done_d = 1'b1;
        end else if (to_q == TO_LAST) begin
          state_d     = S_IDLE;
          calc_en_d   = 1'b0;
          to_d        = '0;
          job_done_d  = 1'b1;
          job_error_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      to_q        <= '0;
      mem_en_q    <= 1'b0;
      read_en_q   <= 1'b0;
      calc_en_q   <= 1'b0;
      row_addr_q  <= '0;
      col_addr_q  <= '0;
      wdata_q     <= '0;
      load_done_q <= 1'b0;
      rb_dv_q     <= 1'b0;
      job_done_q  <= 1'b0;
      job_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      to_q        <= to_d;
      mem_en_q    <= mem_en_d;
      read_en_q   <= read_en_d;
      calc_en_q   <= calc_en_d;
      row_addr_q  <= row_addr_d;
      col_addr_q  <= col_addr_d;
      wdata_q     <= wdata_d;
      load_done_q <= load_done_d;
      rb_dv_q     <= rb_dv_d;
      job_done_q  <= job_done_d;
      job_error_q <= job_error_d;
    end
  end

endmodule

// File: tb/tb_xbar_job_ctrl.sv
// Self-checking bench for xbar_job_ctrl with a behavioural tile model and
// scoreboards for tile writes and readback data.
module tb_xbar_job_ctrl;

  localparam int unsigned XR   = 8;
  localparam int unsigned XC   = 16;
  localparam int unsigned AW   = 32;
  localparam int unsigned TO   = 4096;
  localparam int          TLAT = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start, w_valid, w_ready, load_done;
  logic [7:0]    w_data;
  logic          rb_valid, rb_ready, rb_data_valid;
  logic [AW-1:0] rb_row, rb_col;
  logic [7:0]    rb_data;
  logic          job_valid, job_ready, job_done, job_error, busy;
  logic          xb_mem_en, xb_read_en, xb_calc_en;
  logic [AW-1:0] xb_row_address, xb_col_address;
  logic [7:0]    xb_mem_write_in, xb_mem_read_out;
  logic          xb_available;

  xbar_job_ctrl #(.XBAR_R(XR), .XBAR_C(XC), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .load_done(load_done),
    .rb_valid(rb_valid), .rb_row(rb_row), .rb_col(rb_col), .rb_ready(rb_ready),
    .rb_data_valid(rb_data_valid), .rb_data(rb_data),
    .job_valid(job_valid), .job_ready(job_ready), .job_done(job_done),
    .job_error(job_error), .busy(busy),
    .xb_mem_en(xb_mem_en), .xb_read_en(xb_read_en), .xb_calc_en(xb_calc_en),
    .xb_row_address(xb_row_address), .xb_col_address(xb_col_address),
    .xb_mem_write_in(xb_mem_write_in), .xb_mem_read_out(xb_mem_read_out),
    .xb_available(xb_available)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- tile model ----------------
  logic [7:0] tile_mem [XR*XC];
  logic [7:0] rd_q = 8'd0;
  logic       avail_q = 1'b1;
  logic       tie_avail = 1'b0;
  logic       tile_busy = 1'b0;
  logic       tile_hold = 1'b0;
  int         tile_cnt = 0;
  int         tile_passes = 0;

  assign xb_available    = tie_avail ? 1'b1 : avail_q;
  assign xb_mem_read_out = rd_q;

  function automatic int tidx(input logic [AW-1:0] r, input logic [AW-1:0] c);
    if (r < AW'(XR) && c < AW'(XC)) return int'(r) * int'(XC) + int'(c);
    return -1;
  endfunction

  always @(posedge clk) begin
    if (xb_mem_en && !xb_read_en && tidx(xb_row_address, xb_col_address) >= 0)
      tile_mem[tidx(xb_row_address, xb_col_address)] <= xb_mem_write_in;
    if (xb_mem_en && xb_read_en && tidx(xb_row_address, xb_col_address) >= 0)
      rd_q <= tile_mem[tidx(xb_row_address, xb_col_address)];
    // Compute pass: available low for TLAT+1 cycles, then a settle cycle in
    // which calc_en is ignored; calc_en still high after that restarts the tile.
    if (tile_busy) begin
      if (tile_cnt == 0) begin
        avail_q   <= 1'b1;
        tile_busy <= 1'b0;
        tile_hold <= 1'b1;
      end else begin
        tile_cnt <= tile_cnt - 1;
      end
    end else if (tile_hold) begin
      tile_hold <= 1'b0;
    end else if (xb_calc_en && !tie_avail) begin
      avail_q     <= 1'b0;
      tile_busy   <= 1'b1;
      tile_cnt    <= TLAT;
      tile_passes <= tile_passes + 1;
    end
  end

  // ---------------- scoreboards / monitors ----------------
  typedef struct {
    int         row;
    int         col;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int writes = 0, reads = 0, ld_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (xb_mem_en && !xb_read_en) begin
      writes++;
      if (wq.size() == 0) begin
        chk("unexpected_write", xb_row_address, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_row", xb_row_address, e.row);
        chk("wr_col", xb_col_address, e.col);
        chk("wr_data", {24'd0, xb_mem_write_in}, {24'd0, e.data});
      end
    end
    if (xb_read_en) reads++;
    if (load_done) ld_cnt++;
    if (job_done) done_cnt++;
    if (rb_data_valid) begin
      if (rq.size() == 0) chk("unexpected_rb_data", {24'd0, rb_data}, 32'hFFFF_FFFF);
      else chk("rb_data", {24'd0, rb_data}, {24'd0, rq.pop_front()});
    end
    if (xb_mem_en && xb_calc_en) chk1("mem_calc_exclusive", 1'b1, 1'b0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- vector tables ----------------
  typedef struct {
    logic cfg, rb, job;
    logic e_rb_ready, e_job_ready;
  } arb_t;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] exp;
  } rbv_t;

  arb_t arb[8];
  rbv_t rbv[5];

  initial begin
    int passes0, done0, reads0, rise, held_bad, a;
    logic got, seen_low;

    arb[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    arb[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    arb[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    arb[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    arb[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    arb[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    arb[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    arb[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rbv[0] = '{3, 5, 8'd8};
    rbv[1] = '{0, 0, 8'd0};
    rbv[2] = '{7, 15, 8'd22};
    rbv[3] = '{5, 10, 8'd15};
    rbv[4] = '{7, 0, 8'd7};

    reset = 1'b1; cfg_start = 1'b0; w_valid = 1'b0; w_data = 8'd0;
    rb_valid = 1'b0; rb_row = '0; rb_col = '0; job_valid = 1'b0;

    // Reset state
    tick(); tick(); tick();
    smp();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", xb_mem_en, 1'b0);
    chk1("rst_read_en", xb_read_en, 1'b0);
    chk1("rst_calc_en", xb_calc_en, 1'b0);
    chk("rst_row_addr", xb_row_address, 32'd0);
    chk("rst_col_addr", xb_col_address, 32'd0);
    chk("rst_wdata", {24'd0, xb_mem_write_in}, 32'd0);
    chk1("rst_w_ready", w_ready, 1'b0);
    chk1("rst_job_ready", job_ready, 1'b1);
    chk1("rst_rb_ready", rb_ready, 1'b1);
    chk1("rst_pulses", load_done | rb_data_valid | job_done | job_error, 1'b0);

    // Arbitration priority table; reset held so the FSM stays in IDLE
    for (int i = 0; i < 8; i++) begin
      tick();
      cfg_start = arb[i].cfg; rb_valid = arb[i].rb; job_valid = arb[i].job;
      smp();
      chk1($sformatf("arb%0d_rb_ready", i), rb_ready, arb[i].e_rb_ready);
      chk1($sformatf("arb%0d_job_ready", i), job_ready, arb[i].e_job_ready);
    end
    tick();
    cfg_start = 1'b0; rb_valid = 1'b0; job_valid = 1'b0; reset = 1'b0;
    tick();

    // Full weight load, w_valid toggling every cycle
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    smp();
    chk1("load_busy", busy, 1'b1);
    chk1("load_w_ready", w_ready, 1'b1);
    chk1("load_rb_ready", rb_ready, 1'b0);
    chk1("load_job_ready", job_ready, 1'b0);
    for (int r = 0; r < int'(XR); r++) begin
      for (int c = 0; c < int'(XC); c++) begin
        w_valid = 1'b1;
        w_data  = 8'(r + c);
        wq.push_back('{r, c, 8'(r + c)});
        tick();
        w_valid = 1'b0;
        if (r == int'(XR) - 1 && c == int'(XC) - 1) begin
          smp();
          chk1("load_done_last", load_done, 1'b1);
          chk1("load_idle_after", busy, 1'b0);
        end else begin
          tick();
        end
      end
    end
    tick();
    smp();
    chk1("load_done_clear", load_done, 1'b0);
    chk("load_write_count", writes, XR * XC);
    chk("load_done_count", ld_cnt, 1);
    chk("load_wq_empty", wq.size(), 0);

    // Readback table: data is row+col from the load above
    for (int i = 0; i < 5; i++) begin
      tick();
      rb_valid = 1'b1; rb_row = AW'(rbv[i].row); rb_col = AW'(rbv[i].col);
      smp();
      chk1($sformatf("rb%0d_ready", i), rb_ready, 1'b1);
      rq.push_back(rbv[i].exp);
      reads0 = reads;
      tick();
      rb_valid = 1'b0;
      smp();
      chk1($sformatf("rb%0d_read_en", i), xb_read_en, 1'b1);
      chk1($sformatf("rb%0d_dv_early", i), rb_data_valid, 1'b0);
      tick();
      smp();
      chk1($sformatf("rb%0d_dv", i), rb_data_valid, 1'b1);
      chk1($sformatf("rb%0d_idle", i), busy, 1'b0);
      tick();
      smp();
      chk1($sformatf("rb%0d_dv_pulse", i), rb_data_valid, 1'b0);
      chk($sformatf("rb%0d_read_cycles", i), reads - reads0, 1);
    end

    // Compute job against the tile model
    tick();
    job_valid = 1'b1;
    smp();
    chk1("job_ready", job_ready, 1'b1);
    passes0 = tile_passes; done0 = done_cnt;
    tick();
    job_valid = 1'b0;
    got = 1'b0; seen_low = 1'b0; rise = -1; held_bad = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      smp();
      if (job_done) got = 1'b1;
      else begin
        if (!xb_calc_en) held_bad++;
        if (!xb_available) seen_low = 1'b1;
        else if (seen_low && rise < 0) rise = cyc;
      end
      if (!got) tick();
    end
    chk1("job_done_seen", got, 1'b1);
    chk1("job_error_clear", job_error, 1'b0);
    chk1("job_calc_dropped", xb_calc_en, 1'b0);
    chk("job_done_cycle", cyc, rise + 1);
    chk("job_calc_held", held_bad, 0);
    for (int k = 0; k < 20; k++) tick();
    chk("job_tile_passes", tile_passes - passes0, 1);
    chk("job_done_pulses", done_cnt - done0, 1);

    // Timeout: available never drops
    tie_avail = 1'b1;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    a = cyc;
    got = 1'b0;
    for (int k = 0; k < int'(TO) + 50 && !got; k++) begin
      smp();
      if (job_done) got = 1'b1;
      else tick();
    end
    chk1("to_done_seen", got, 1'b1);
    chk("to_done_cycle", cyc, a + int'(TO));
    chk1("to_error", job_error, 1'b1);
    chk1("to_calc_off", xb_calc_en, 1'b0);
    tick();
    smp();
    chk1("to_done_pulse", job_done, 1'b0);
    chk1("to_error_pulse", job_error, 1'b0);
    chk1("to_idle", busy, 1'b0);
    tie_avail = 1'b0;

    // All three requests at once, then reset at beat 100 of the load
    tick();
    cfg_start = 1'b1; rb_valid = 1'b1; job_valid = 1'b1; rb_row = 32'd1; rb_col = 32'd1;
    smp();
    chk1("all3_rb_ready", rb_ready, 1'b0);
    chk1("all3_job_ready", job_ready, 1'b0);
    tick();
    cfg_start = 1'b0; rb_valid = 1'b0; job_valid = 1'b0;
    smp();
    chk1("all3_load", w_ready, 1'b1);
    chk1("all3_no_calc", xb_calc_en, 1'b0);
    chk1("all3_no_read", xb_read_en, 1'b0);
    tick();
    for (int b = 0; b < 100; b++) begin
      w_valid = 1'b1;
      w_data  = 8'(b ^ 32'h5A);
      wq.push_back('{b / int'(XC), b % int'(XC), 8'(b ^ 32'h5A)});
      tick();
      w_valid = 1'b0;
      tick();
    end
    w_valid = 1'b1; w_data = 8'hEE; reset = 1'b1;
    tick();
    w_valid = 1'b0; reset = 1'b0;
    smp();
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_mem_en", xb_mem_en, 1'b0);
    chk1("mid_rst_w_ready", w_ready, 1'b0);
    chk("mid_rst_row_addr", xb_row_address, 32'd0);
    chk("mid_rst_col_addr", xb_col_address, 32'd0);
    chk("mid_rst_wdata", {24'd0, xb_mem_write_in}, 32'd0);
    chk("mid_rst_wq_empty", wq.size(), 0);
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    w_valid = 1'b1; w_data = 8'hA5;
    wq.push_back('{0, 0, 8'hA5});
    tick();
    w_valid = 1'b0;
    smp();
    chk1("restart_write", xb_mem_en, 1'b1);
    chk("restart_row", xb_row_address, 32'd0);
    chk("restart_col", xb_col_address, 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("final_wq_empty", wq.size(), 0);
    chk("final_rq_empty", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
